// File: rtl/bundle_accumulator.sv
// Signed vote accumulator: N core votes per update are reduced through a 3-stage adder pipeline into box.
// Define BUNDLE_ACCUMULATOR_SAT_EN to clamp box and report sticky overflow instead of wrapping.
module bundle_accumulator #(
  parameter int N = 4,
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         tmp_even,
  input  logic         tmp_rand_bit,
  input  logic [N-1:0] core_enable,
  input  logic [N-1:0] core_result,
  input  logic         update,
  input  logic         finish,
  output logic         busy,
  output logic         done,
  output logic         sign_bit,
  output logic         overflow
);

  localparam int G  = N / 4;
  localparam int TW = $clog2(N) + 2;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t state, state_nxt;
  logic [1:0] drain_cnt;

  logic signed [1:0]    vote_p0 [N];
  logic signed [3:0]    grp_sum [G];
  logic signed [3:0]    grp_p1  [G];
  logic signed [TW-1:0] total;
  logic signed [TW-1:0] total_p2;
  logic                 vld_p0, vld_p1, vld_p2;
  logic signed [W-1:0]  box;

  logic accept, load;
  assign accept = update && (state == ACCUM);
  assign load   = start && (state == IDLE);

  function automatic logic signed [1:0] vote(input logic en, input logic res);
    if (!en) return 2'sb00;
    return res ? 2'sb01 : 2'sb11;
  endfunction

`ifdef BUNDLE_ACCUMULATOR_SAT_EN
  function automatic logic signed [W-1:0] sat(input logic signed [W:0] s);
    if (s[W] != s[W-1])
      return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return s[W-1:0];
  endfunction

  function automatic logic clipped(input logic signed [W:0] s);
    return s[W] != s[W-1];
  endfunction
`else
  function automatic logic signed [W-1:0] wrap_add(input logic signed [W-1:0] a,
                                                   input logic signed [TW-1:0] t);
    return a + W'(t);
  endfunction
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (finish) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == 2'd2) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      ACCUM, DRAIN: busy = 1'b1;
      DONE:         done = 1'b1;
      default:      ;
    endcase
  end

  always_comb begin
    for (int g = 0; g < G; g++) begin
      grp_sum[g] = 4'sd0;
      for (int i = 0; i < 4; i++)
        grp_sum[g] = grp_sum[g] + 4'(vote_p0[4*g+i]);
    end
  end

  always_comb begin
    total = '0;
    for (int g = 0; g < G; g++)
      total = total + TW'(grp_p1[g]);
  end

  // E0 votes -> E1 group sums -> E2 total; a start or reset flushes in-flight votes
  always_ff @(posedge clk) begin
    if (rst || load) begin
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      total_p2 <= '0;
      for (int i = 0; i < N; i++) vote_p0[i] <= 2'sb00;
      for (int g = 0; g < G; g++) grp_p1[g] <= 4'sd0;
    end else begin
      vld_p0   <= accept;
      vld_p1   <= vld_p0;
      vld_p2   <= vld_p1;
      total_p2 <= total;
      for (int i = 0; i < N; i++) vote_p0[i] <= vote(core_enable[i] & accept, core_result[i]);
      for (int g = 0; g < G; g++) grp_p1[g] <= grp_sum[g];
    end
  end

  // E3 accumulate; start seeds box with the tie-break bias
`ifdef BUNDLE_ACCUMULATOR_SAT_EN
  logic signed [W:0] sum_ext;
  logic              ovf;
  assign sum_ext = (W+1)'(box) + (W+1)'(total_p2);

  always_ff @(posedge clk) begin
    if (rst) begin
      box <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      box <= tmp_even ? (tmp_rand_bit ? {W{1'b1}} : W'(1)) : '0;
      ovf <= 1'b0;
    end else if (vld_p2) begin
      box <= sat(sum_ext);
      ovf <= ovf | clipped(sum_ext);
    end
  end
  assign overflow = ovf;
`else
  always_ff @(posedge clk) begin
    if (rst)
      box <= '0;
    else if (load)
      box <= tmp_even ? (tmp_rand_bit ? {W{1'b1}} : W'(1)) : '0;
    else if (vld_p2)
      box <= wrap_add(box, total_p2);
  end
  assign overflow = 1'b0;
`endif

  assign sign_bit = box[W-1];

endmodule

// File: tb/tb_bundle_accumulator.sv
// Bench for bundle_accumulator (N=8, W=8): directed and random bundles against an arithmetic reference.
module tb_bundle_accumulator;
  localparam int N = 8;
  localparam int W = 8;
  localparam int BMAX = (1 << (W-1)) - 1;
  localparam int BMIN = -(1 << (W-1));

  logic clk = 1'b0;
  logic rst, start, tmp_even, tmp_rand_bit, update, finish;
  logic [N-1:0] core_enable, core_result;
  logic busy, done, sign_bit, overflow;

  bundle_accumulator #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .tmp_even(tmp_even), .tmp_rand_bit(tmp_rand_bit),
    .core_enable(core_enable), .core_result(core_result), .update(update), .finish(finish),
    .busy(busy), .done(done), .sign_bit(sign_bit), .overflow(overflow));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int mbox;
  bit movf;
  logic [N-1:0] en_a [64];
  logic [N-1:0] res_a [64];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic int votes(input logic [N-1:0] en, input logic [N-1:0] res);
    int s = 0;
    for (int i = 0; i < N; i++)
      if (en[i]) s += res[i] ? 1 : -1;
    return s;
  endfunction

  function automatic void madd(input int v);
    int s = mbox + v;
`ifdef BUNDLE_ACCUMULATOR_SAT_EN
    if (s > BMAX) begin s = BMAX; movf = 1'b1; end
    else if (s < BMIN) begin s = BMIN; movf = 1'b1; end
`else
    s = s & ((1 << W) - 1);
    if (s > BMAX) s -= (1 << W);
`endif
    mbox = s;
  endfunction

  // One bundle of n updates; noise injects start in ACCUM/DONE and updates in DRAIN, all to be ignored
  task automatic bundle(input string tag, input bit ev, input bit rb, input int n,
                        input bit fin_last, input bit noise);
    start = 1'b1; tmp_even = ev; tmp_rand_bit = rb;
    tick();
    start = 1'b0;
    mbox = ev ? (rb ? -1 : 1) : 0;
    movf = 1'b0;
    chk({tag, "_busy_accum"}, busy, 1'b1);
    for (int i = 0; i < n; i++) begin
      update = 1'b1; core_enable = en_a[i]; core_result = res_a[i];
      finish = fin_last && (i == n - 1);
      if (noise && i == 1) begin start = 1'b1; tmp_even = 1'b1; tmp_rand_bit = ~rb; end
      tick();
      start = 1'b0;
      madd(votes(en_a[i], res_a[i]));
    end
    if (!fin_last) begin
      update = 1'b0; finish = 1'b1;
      tick();
    end
    update = 1'b0; finish = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk({tag, "_done_drain"}, done, 1'b0);
      chk({tag, "_busy_drain"}, busy, 1'b1);
      if (noise) begin update = 1'b1; core_enable = '1; core_result = N'($urandom); end
      tick();
      update = 1'b0;
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_busy_done"}, busy, 1'b0);
    chk({tag, "_sign"}, sign_bit, mbox < 0);
    chk({tag, "_ovf"}, overflow, movf);
    if (noise) begin start = 1'b1; tmp_even = 1'b1; tmp_rand_bit = ~sign_bit; end
    tick();
    start = 1'b0;
    chk({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    chk({tag, "_sign_hold"}, sign_bit, mbox < 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tmp_even = 1'b0; tmp_rand_bit = 1'b0;
    update = 1'b0; finish = 1'b0; core_enable = '0; core_result = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sign", sign_bit, 1'b0);
    chk("rst_ovf", overflow, 1'b0);

    // three enabled +1, one -1 -> +2
    en_a[0] = 8'h0F; res_a[0] = 8'h0E;
    bundle("plus2", 1'b0, 1'b0, 1, 1'b0, 1'b0);

    // balanced votes: bias alone decides
    en_a[0] = 8'hFF; res_a[0] = 8'hCC; en_a[1] = 8'hFF; res_a[1] = 8'h33;
    bundle("tie_neg", 1'b1, 1'b1, 2, 1'b1, 1'b0);
    bundle("tie_pos", 1'b1, 1'b0, 2, 1'b1, 1'b0);
    bundle("tie_none", 1'b0, 1'b1, 2, 1'b0, 1'b0);

    // back-to-back all -1 -> -80
    for (int i = 0; i < 10; i++) begin en_a[i] = 8'hFF; res_a[i] = 8'h00; end
    bundle("b2b_m80", 1'b0, 1'b0, 10, 1'b1, 1'b0);

    // disabled channels -> +6, then IDLE updates must not move box
    for (int i = 0; i < 3; i++) begin en_a[i] = 8'h05; res_a[i] = 8'hFF; end
    bundle("disabled", 1'b0, 1'b0, 3, 1'b0, 1'b1);
    update = 1'b1; core_enable = 8'hFF; core_result = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    update = 1'b0;
    tick(); tick(); tick();
    chk("idle_update_ignored", sign_bit, 1'b0);

    // +128 overflows an 8-bit box
    for (int i = 0; i < 16; i++) begin en_a[i] = 8'hFF; res_a[i] = 8'hFF; end
    bundle("overflow", 1'b0, 1'b0, 16, 1'b1, 1'b0);

    // near-zero negative sum, no bias
    en_a[0] = 8'h01; res_a[0] = 8'h00;
    bundle("minus1", 1'b0, 1'b0, 1, 1'b1, 1'b1);

    // reset two cycles after an update discards everything
    start = 1'b1; tmp_even = 1'b1; tmp_rand_bit = 1'b1;
    tick();
    start = 1'b0; update = 1'b1; core_enable = 8'hFF; core_result = 8'h00;
    tick();
    update = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_sign", sign_bit, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("rst_mid_no_done", done, 1'b0);
      tick();
    end
    chk("rst_mid_sign_late", sign_bit, 1'b0);
    chk("rst_mid_ovf", overflow, 1'b0);

    // random bundles; vote mix biased toward small totals so the sign stays sensitive
    for (int b = 0; b < 24; b++) begin
      int n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) begin
        en_a[i] = N'($urandom);
        res_a[i] = N'($urandom);
      end
      bundle($sformatf("rand%0d", b), 1'($urandom), 1'($urandom), n, 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/bundle_accumulator.md
BUNDLE_ACCUMULATOR -- requirements
Module: bundle_accumulator

Interface
REQ-001 Parameter N, default 4: number of core channels; SHALL be a multiple of 4, range 4..64.
REQ-002 Parameter W, default 30: signed accumulator width; SHALL be at least clog2(N)+2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  begin new bundle; samples tmp_even/tmp_rand_bit for bias.
REQ-006 tmp_even  input  1  bundle element count is even; apply tie-break bias.
REQ-007 tmp_rand_bit  input  1  bias sign: 0 gives +1, 1 gives -1.
REQ-008 core_enable  input  N  per-channel enable for the current update.
REQ-009 core_result  input  N  per-channel result bit for the current update.
REQ-010 update  input  1  one vote vector valid this cycle.
REQ-011 finish  input  1  no further updates; drain and report.
REQ-012 busy  output  1  high in ACCUM and DRAIN.
REQ-013 done  output  1  one-cycle pulse when sign_bit is final.
REQ-014 sign_bit  output  1  accumulator MSB (box[W-1]).
REQ-015 overflow  output  1  sticky saturation indicator.

Function
REQ-016 Channel vote SHALL be: enable 0 gives 0; enable 1 and result 1 gives +1; enable 1 and result 0 gives -1.
REQ-017 Pipeline SHALL be: E0 votes registered; E1 N/4 group sums of 4 votes registered; E2 total of group sums registered; E3 box <= box + total; update at edge k affects box at edge k+3.
REQ-018 Pipeline SHALL accept update on every cycle (back-to-back), with no vote dropped or double-counted.
REQ-019 States: IDLE, ACCUM, DRAIN, DONE; transitions: IDLE--start-->ACCUM; ACCUM--finish-->DRAIN; DRAIN--3 cycles-->DONE; DONE--1 cycle-->IDLE.
REQ-020 On start in IDLE, box SHALL load +1 if tmp_even and not tmp_rand_bit, -1 if tmp_even and tmp_rand_bit, else 0; overflow clears; pipeline registers clear.
REQ-021 update SHALL be accepted only in ACCUM; update in IDLE, DRAIN or DONE is ignored.
REQ-022 update and finish in the same ACCUM cycle: the update SHALL be accepted, then DRAIN.
REQ-023 start outside IDLE SHALL be ignored; start in DONE is ignored (next start is valid in IDLE).
REQ-024 done SHALL be asserted only in DONE; sign_bit is held stable from DONE until next start.
REQ-025 Total sum width SHALL be clog2(N)+2 signed, sign-extended to W before accumulation.

Reset
REQ-026 rst SHALL force IDLE, box=0, all pipeline registers=0, busy=0, done=0, overflow=0, sign_bit=0.
REQ-027 rst SHALL take priority over every other input, including mid-ACCUM or mid-DRAIN, discarding in-flight votes.

Configuration
REQ-028 Macro BUNDLE_ACCUMULATOR_SAT_EN: when defined, box SHALL clamp to [-2^(W-1), 2^(W-1)-1] and overflow SHALL set on any clamp and stay set until start or rst.
REQ-029 Without BUNDLE_ACCUMULATOR_SAT_EN, box SHALL wrap two's-complement and overflow SHALL be constant 0.

Verification
REQ-030 N=4: start (tmp_even=0), one update enable=1111 result=1110, finish -> box=+2, done pulse 4 cycles after finish cycle, sign_bit=0.
REQ-031 N=4: start (tmp_even=1, rand=1), updates result=1100 and result=0011 all enabled -> box=-1, sign_bit=1; with rand=0 -> box=+1, sign_bit=0.
REQ-032 N=8: 10 back-to-back updates enable=FF result=00, finish on last -> box=-80, sign_bit=1, no dropped votes.
REQ-033 Disabled channels: N=4, enable=0101 result=1111 x3 -> box=+6; update in IDLE and DRAIN leaves box unchanged.
REQ-034 W=4, N=4, with SAT_EN: 3 updates all +1 -> box=7, overflow=1; without SAT_EN -> box wraps to -4, overflow=0.
REQ-035 rst asserted two cycles after an update in ACCUM -> IDLE, box=0, done never pulses, busy=0 next cycle.
